// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes the A/B channels, debounces the
// two-bit level with a stability filter, and turns accepted level changes
// into a signed position count with step/dir pulses and a sticky error flag.
// There are no valid/ready handshakes: clear, latch and err_clr are single-cycle
// strobes that act on the next rising edge of clk.
module quad_decoder #(
  parameter int POS_W    = 32,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  input  logic             latch,
  input  logic             err_clr,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] position_latched,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN);

  // Phase index along the increment sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       acc_q, acc_d;
  logic             primed_q, primed_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [POS_W-1:0] latched_q, latched_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic             accept;
  logic             stable;
  logic             differs;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       delta;

  // Synchronizer, filter and decode: next-state for every register.
  always_comb begin
    sync1_d    = {enc_a, enc_b};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    stable     = (sync2_q == prev_q);
    // Before priming every level counts as new, even one equal to acc_q.
    differs    = !primed_q || (sync2_q != acc_q);
    cnt_inc    = cnt_q + 1'b1;
    cnt_d      = '0;
    accept     = 1'b0;
    if (stable && differs) begin
      if (cnt_inc == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    delta      = phase_of(sync2_q) - phase_of(acc_q);
    acc_d      = acc_q;
    primed_d   = primed_q;
    position_d = position_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_clr ? 1'b0 : err_q;
    latched_d  = latch ? position_q : latched_q;

    if (accept) begin
      acc_d    = sync2_q;
      primed_d = 1'b1;
      if (primed_q) begin
        case (delta)
          2'd1: begin
            position_d = position_q + POS_W'(1);
            step_d     = 1'b1;
            dir_d      = 1'b1;
          end
          2'd3: begin
            position_d = position_q - POS_W'(1);
            step_d     = 1'b1;
            dir_d      = 1'b0;
          end
          2'd2:    err_d = 1'b1;
          default: ;
        endcase
      end
    end

    // Clear wins over a same-cycle count but leaves step/dir untouched.
    if (clear) begin
      position_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      primed_q   <= 1'b0;
      position_q <= '0;
      latched_q  <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      primed_q   <= primed_d;
      position_q <= position_d;
      latched_q  <= latched_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign position         = position_q;
  assign position_latched = latched_q;
  assign step             = step_q;
  assign dir              = dir_q;
  assign err              = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: a 32-bit and an 8-bit instance share all inputs and
// are compared against a level-based model of the encoder (phase indices along
// the increment sequence, a level counts once it has been held long enough).
module tb_quad_decoder;

  localparam int FILT_LEN = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, enc_a, enc_b, clear, latch, err_clr;
  logic [31:0] pos32, plat32;
  logic [7:0]  pos8, plat8;
  logic        step32, dir32, err32, step8, dir8, err8;

  always #5 clk = ~clk;

  quad_decoder #(.POS_W(32), .FILT_LEN(FILT_LEN)) u_dut32 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .latch(latch), .err_clr(err_clr), .position(pos32),
    .position_latched(plat32), .step(step32), .dir(dir32), .err(err32)
  );

  quad_decoder #(.POS_W(8), .FILT_LEN(FILT_LEN)) u_dut8 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .latch(latch), .err_clr(err_clr), .position(pos8),
    .position_latched(plat8), .step(step8), .dir(dir8), .err(err8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  longint     m_pos;
  longint     m_latched;
  logic       m_dir, m_err, m_primed;
  logic [1:0] m_acc, m_drv;

  function automatic int ph_of(input logic [1:0] ab);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] ab_of(input int idx);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    return seq[idx % 4];
  endfunction

  task automatic model_reset();
    m_pos = 0; m_latched = 0; m_dir = 1'b0; m_err = 1'b0;
    m_primed = 1'b0; m_acc = 2'b00;
  endtask

  // A level held for at least FILT_LEN+1 cycles is accepted.
  task automatic model_apply(input logic [1:0] ab, input int hold);
    int d;
    m_drv = ab;
    if (hold >= FILT_LEN + 1) begin
      if (!m_primed) begin
        m_primed = 1'b1;
        m_acc    = ab;
      end else if (ab != m_acc) begin
        d = (ph_of(ab) - ph_of(m_acc) + 4) % 4;
        if (d == 1) begin m_pos++; m_dir = 1'b1; end
        else if (d == 3) begin m_pos--; m_dir = 1'b0; end
        else m_err = 1'b1;
        m_acc = ab;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_level(input logic [1:0] ab, input int hold);
    {enc_a, enc_b} = ab;
    repeat (hold) @(negedge clk);
    model_apply(ab, hold);
  endtask

  task automatic step_fwd(input int hold);
    drive_level(ab_of(ph_of(m_drv) + 1), hold);
  endtask

  task automatic step_bwd(input int hold);
    drive_level(ab_of(ph_of(m_drv) + 3), hold);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    m_pos = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; latch = 1'b0; err_clr = 1'b0;
    enc_a = 1'b0; enc_b = 1'b0; m_drv = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (pos32 !== 32'd0) begin n_fail++; $display("FAIL reset_pos32 got %h exp 0", pos32); end
    n_checks++; if (pos8 !== 8'd0) begin n_fail++; $display("FAIL reset_pos8 got %h exp 0", pos8); end
    n_checks++; if (plat32 !== 32'd0) begin n_fail++; $display("FAIL reset_latched got %h exp 0", plat32); end
    n_checks++; if ({step32, dir32, err32} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {step32, dir32, err32}); end
  endtask

  task automatic test_count_up();
    drive_level(2'b00, 10);
    for (int i = 0; i < 123 * 4; i++) step_fwd(10);
    latch = 1'b1; @(negedge clk); latch = 1'b0;
    m_latched = m_pos;
    n_checks++; if (plat32 !== 32'd492) begin n_fail++; $display("FAIL up_latched32 got %0d exp 492", plat32); end
    n_checks++; if (plat8 !== 8'(m_latched)) begin n_fail++; $display("FAIL up_latched8 got %h exp %h", plat8, 8'(m_latched)); end
    n_checks++; if (pos32 !== 32'(m_pos)) begin n_fail++; $display("FAIL up_pos32 got %0d exp %0d", pos32, m_pos); end
    n_checks++; if ({dir32, err32} !== 2'b10) begin n_fail++; $display("FAIL up_dir_err got %b exp 10", {dir32, err32}); end
  endtask

  task automatic test_count_down();
    pulse_clear();
    for (int i = 0; i < 456 * 4; i++) step_bwd(10);
    n_checks++; if (pos32 !== 32'hFFFF_F8E0) begin n_fail++; $display("FAIL down_pos32 got %h exp fffff8e0", pos32); end
    n_checks++; if (pos8 !== 8'hE0) begin n_fail++; $display("FAIL down_pos8 got %h exp e0", pos8); end
    n_checks++; if ({dir32, err32} !== 2'b00) begin n_fail++; $display("FAIL down_dir_err got %b exp 00", {dir32, err32}); end
  endtask

  task automatic test_filter_pulse();
    longint base;
    logic exp_step;
    base = m_pos;
    // 2-cycle A pulse from 00: must be swallowed.
    @(negedge clk); enc_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_checks++; if (step32 !== 1'b0) begin n_fail++; $display("FAIL short_pulse_step k=%0d got %b exp 0", k, step32); end
      if (k == 1) enc_a = 1'b0;
    end
    n_checks++; if (pos32 !== 32'(base)) begin n_fail++; $display("FAIL short_pulse_pos got %0d exp %0d", pos32, base); end
    // 4-cycle A pulse: +1 at edge 5, -1 at edge 9.
    enc_a = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      exp_step = (k == 5) || (k == 9);
      n_checks++; if ({step32, step8} !== {2{exp_step}}) begin n_fail++; $display("FAIL long_pulse_step k=%0d got %b exp %b", k, {step32, step8}, {2{exp_step}}); end
      if (k == 5) begin
        n_checks++; if ({pos32, dir32} !== {32'(base + 1), 1'b1}) begin n_fail++; $display("FAIL long_pulse_up got %0d/%b exp %0d/1", pos32, dir32, base + 1); end
      end
      if (k == 9) begin
        n_checks++; if ({pos32, dir32} !== {32'(base), 1'b0}) begin n_fail++; $display("FAIL long_pulse_down got %0d/%b exp %0d/0", pos32, dir32, base); end
      end
      if (k == 3) enc_a = 1'b0;
    end
    m_dir = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    {enc_a, enc_b} = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (step32 !== 1'b0) begin n_fail++; $display("FAIL illegal_step i=%0d got %b exp 0", i, step32); end
    end
    model_apply(2'b11, 10);
    n_checks++; if ({err32, err8} !== 2'b11) begin n_fail++; $display("FAIL illegal_err got %b exp 11", {err32, err8}); end
    n_checks++; if (pos32 !== 32'(m_pos)) begin n_fail++; $display("FAIL illegal_pos got %0d exp %0d", pos32, m_pos); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
    n_checks++; if (err32 !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b exp 0", err32); end
    drive_level(2'b01, 10);
    n_checks++; if ({pos32, err32} !== {32'(m_pos), 1'b0}) begin n_fail++; $display("FAIL after_illegal_pos got %0d/%b exp %0d/0", pos32, err32, m_pos); end
    // Illegal 01 -> 10 accepted in the same cycle as err_clr: err stays set.
    {enc_a, enc_b} = 2'b10;
    repeat (5) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    model_apply(2'b10, 6);
    n_checks++; if (err32 !== 1'b1) begin n_fail++; $display("FAIL err_clr_collide got %b exp 1", err32); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_wrap_clear();
    logic [1:0] nxt;
    pulse_clear();
    for (int i = 0; i < 127; i++) step_fwd(6);
    n_checks++; if ({pos8, pos32} !== {8'h7F, 32'd127}) begin n_fail++; $display("FAIL preload got %h/%0d exp 7f/127", pos8, pos32); end
    step_fwd(6);
    n_checks++; if ({pos8, pos32} !== {8'h80, 32'd128}) begin n_fail++; $display("FAIL wrap_up got %h/%0d exp 80/128", pos8, pos32); end
    step_bwd(6);
    n_checks++; if (pos8 !== 8'h7F) begin n_fail++; $display("FAIL wrap_down got %h exp 7f", pos8); end
    // Clear and latch in the very cycle a forward step is counted.
    nxt = ab_of(ph_of(m_drv) + 1);
    {enc_a, enc_b} = nxt;
    repeat (5) @(negedge clk);
    clear = 1'b1; latch = 1'b1; @(negedge clk); clear = 1'b0; latch = 1'b0;
    m_latched = m_pos;
    model_apply(nxt, 6);
    m_pos = 0;
    n_checks++; if ({step32, dir32} !== 2'b11) begin n_fail++; $display("FAIL clear_step_dir got %b exp 11", {step32, dir32}); end
    n_checks++; if ({pos32, pos8} !== 40'd0) begin n_fail++; $display("FAIL clear_pos got %0d/%h exp 0", pos32, pos8); end
    n_checks++; if ({plat32, plat8} !== {32'd127, 8'h7F}) begin n_fail++; $display("FAIL latch_before_clear got %0d/%h exp 127/7f", plat32, plat8); end
    @(negedge clk);
    n_checks++; if (step32 !== 1'b0) begin n_fail++; $display("FAIL step_one_cycle got %b exp 0", step32); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] nxt;
    drive_level(ab_of(ph_of(m_drv) + 2), 8);
    step_fwd(8);
    nxt = m_drv ^ 2'b10;
    {enc_a, enc_b} = nxt;
    @(negedge clk);
    rst = 1'b1; latch = 1'b1; clear = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    n_checks++; if ({pos32, plat32} !== 64'd0) begin n_fail++; $display("FAIL mid_rst_pos got %0d/%0d exp 0/0", pos32, plat32); end
    n_checks++; if ({step32, dir32, err32, pos8} !== 11'd0) begin n_fail++; $display("FAIL mid_rst_flags got %b/%h exp 000/00", {step32, dir32, err32}, pos8); end
    rst = 1'b0; latch = 1'b0; clear = 1'b0; err_clr = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++; if (step32 !== 1'b0) begin n_fail++; $display("FAIL prime_step i=%0d got %b exp 0", i, step32); end
    end
    model_apply(nxt, 13);
    step_fwd(10);
    n_checks++; if ({pos32, dir32, err32} !== {32'(m_pos), 1'b1, 1'b0}) begin n_fail++; $display("FAIL after_prime got %0d/%b/%b exp %0d/1/0", pos32, dir32, err32, m_pos); end
  endtask

  task automatic test_random();
    logic [1:0] ab;
    int hold;
    for (int i = 0; i < 60; i++) begin
      ab = ab_of(ph_of(m_drv) + $urandom_range(1, 3));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : $urandom_range(6, 10);
      drive_level(ab, hold);
      if (hold >= 6) begin
        n_checks++; if (pos32 !== 32'(m_pos)) begin n_fail++; $display("FAIL rand_pos32 i=%0d got %0d exp %0d", i, pos32, m_pos); end
        n_checks++; if (pos8 !== 8'(m_pos)) begin n_fail++; $display("FAIL rand_pos8 i=%0d got %h exp %h", i, pos8, 8'(m_pos)); end
        n_checks++; if ({dir32, err32, dir8, err8} !== {m_dir, m_err, m_dir, m_err}) begin n_fail++; $display("FAIL rand_dir_err i=%0d got %b exp %b", i, {dir32, err32, dir8, err8}, {m_dir, m_err, m_dir, m_err}); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_filter_pulse();
    test_illegal();
    test_wrap_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
